// File: rtl/counter_arbiter_if.sv
// counter_arbiter_if -- request/grant bundle between requesters and the
// shared counter arbiter.
//   req    per-requester run request, held until done or abandon
//   limit  packed per-requester terminal values, requester i at [i*N +: N]
//   hold   freezes the running count
//   gnt    one-hot grant of the shared counter
//   done   one-cycle completion pulse to the granted requester
//   busy   a run is in progress
//   count  current shared counter value
// master = requester side, slave = arbiter side.
interface counter_arbiter_if #(
   parameter int N    = 8,
   parameter int NREQ = 4
) ();
   logic [NREQ-1:0]   req;
   logic [NREQ*N-1:0] limit;
   logic              hold;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   done;
   logic              busy;
   logic [N-1:0]      count;

   modport master (
      output req, limit, hold,
      input  gnt, done, busy, count
   );

   modport slave (
      input  req, limit, hold,
      output gnt, done, busy, count
   );
endinterface

// File: rtl/counter_arbiter.sv
// counter_arbiter -- shares one up-counter among NREQ requesters. A granted
// requester gets a counting run from 0 up to its limit (sampled at grant);
// completion pulses done, dropping req abandons the run.
// Ports:
//   clk  sole clock, rising edge
//   rst  synchronous active-high reset
//   bus  counter_arbiter_if.slave (req, limit, hold in; gnt, done, busy, count out)
// Build option: define COUNTER_ARBITER_FIXED_PRIO_EN for fixed priority
// (lowest index wins); default is round-robin.
//
// state | meaning
// IDLE  | no run; grants the next requester on any req
// RUN   | counter owned by gnt; counts to captured limit unless held
module counter_arbiter #(
   parameter int N    = 8,
   parameter int NREQ = 4
) (
   input logic              clk,
   input logic              rst,
   counter_arbiter_if.slave bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] done_q, done_d;
   logic            busy_q, busy_d;
   logic [N-1:0]    count_q, count_d;
   logic [N-1:0]    lim_q, lim_d;
   logic [IW-1:0]   pick;
   logic [NREQ-1:0] pick_oh;
   logic            abandon;
   logic            at_limit;

`ifndef COUNTER_ARBITER_FIXED_PRIO_EN
   logic [IW-1:0]   last_q, last_d;
`endif

   // Later loop iterations override earlier ones, so each loop runs from
   // lowest to highest priority.
   always_comb begin
      pick = '0;
`ifdef COUNTER_ARBITER_FIXED_PRIO_EN
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (bus.req[i]) pick = IW'(i);
      end
`else
      for (int k = NREQ; k >= 1; k--) begin
         if (bus.req[(int'(last_q) + k) % NREQ]) pick = IW'((int'(last_q) + k) % NREQ);
      end
`endif
   end

   assign pick_oh  = NREQ'(1) << pick;
   assign abandon  = ((bus.req & gnt_q) == '0);
   assign at_limit = (count_q == lim_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         count_q <= '0;
         lim_q   <= '0;
`ifndef COUNTER_ARBITER_FIXED_PRIO_EN
         last_q  <= IW'(NREQ - 1);
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         count_q <= count_d;
         lim_q   <= lim_d;
`ifndef COUNTER_ARBITER_FIXED_PRIO_EN
         last_q  <= last_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|bus.req) state_d = RUN;
         RUN:     if (abandon || (!bus.hold && at_limit)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Computes the next value of every output register; abandon is tested
   // before completion so it wins when both happen together.
   always_comb begin
      gnt_d   = gnt_q;
      done_d  = '0;
      busy_d  = busy_q;
      count_d = count_q;
      lim_d   = lim_q;
`ifndef COUNTER_ARBITER_FIXED_PRIO_EN
      last_d  = last_q;
`endif
      case (state_q)
         IDLE: begin
            gnt_d  = '0;
            busy_d = 1'b0;
            if (|bus.req) begin
               gnt_d   = pick_oh;
               busy_d  = 1'b1;
               count_d = '0;
               lim_d   = bus.limit[int'(pick) * N +: N];
`ifndef COUNTER_ARBITER_FIXED_PRIO_EN
               last_d  = pick;
`endif
            end
         end
         RUN: begin
            if (abandon) begin
               gnt_d  = '0;
               busy_d = 1'b0;
            end else if (bus.hold) begin
               count_d = count_q;
            end else if (at_limit) begin
               done_d = gnt_q;
               gnt_d  = '0;
               busy_d = 1'b0;
            end else begin
               count_d = count_q + N'(1);
            end
         end
         default: begin
            gnt_d  = '0;
            busy_d = 1'b0;
         end
      endcase
   end

   assign bus.gnt   = gnt_q;
   assign bus.done  = done_q;
   assign bus.busy  = busy_q;
   assign bus.count = count_q;
endmodule
